pc_fetch: RTL and testbench

//  Program-counter register and instruction-fetch sequencer for the single-issue core.

---
 rtl/pc_fetch_pkg.sv | 20 ++
 rtl/pc_fetch.sv | 138 +++++++++++++
 tb/tb_pc_fetch.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch stage and the PC/operand mux stage:
// default PC and instruction widths, fetch FSM state encodings and a small
// alignment helper.
package pc_fetch_pkg;

  localparam int PC_SIZE_DEF   = 10;
  localparam int DATA_SIZE_DEF = 32;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

  // Instruction words are 4 bytes; a byte address is word aligned when its two LSBs are zero.
  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch.sv
// Program-counter register and instruction-fetch sequencer.
// Holds current_pc, fetches the word at current_pc from instruction memory,
// presents it to decode and loads next_pc when the controller retires the
// instruction.
//
// Build option: PC_MISALIGN_TRAP_EN
//   defined   - a misaligned next_pc is not loaded; it sets a sticky
//               misalign_fault and parks the FSM in S_HALT until reset.
//   undefined - next_pc is loaded with its two LSBs cleared and
//               misalign_fault is tied to 0.
//
// Handshake (instruction memory): im_req is the request/valid, im_ready the
// acceptance. A transfer happens on a posedge where im_req and im_ready are
// both 1; im_rdata is captured in that same cycle. Once raised, im_req and
// im_addr hold steady until the transfer; only reset can withdraw a request.
// im_ready while im_req is low is ignored.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int                PcSize   = PC_SIZE_DEF,
  parameter int                DataSize = DATA_SIZE_DEF,
  parameter logic [PcSize-1:0] ResetPc  = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                halt,
  input  logic                pc_write,
  input  logic [PcSize-1:0]   next_pc,
  output logic                im_req,
  output logic [PcSize-1:0]   im_addr,
  input  logic                im_ready,
  input  logic [DataSize-1:0] im_rdata,
  output logic [PcSize-1:0]   current_pc,
  output logic [DataSize-1:0] instr,
  output logic                instr_valid,
  output logic                halted,
  output logic                misalign_fault,
  output logic [1:0]          fsm_state
);

  fetch_state_e        state_q;
  fetch_state_e        state_d;
  logic                started_q;
  logic [PcSize-1:0]   pc_q;
  logic [DataSize-1:0] instr_q;
  logic                fault_q;

  logic                fetch_done;
  logic                retire;
  logic                bad_target;
  logic                pc_load;
  logic [PcSize-1:0]   load_value;

  // started_q keeps im_req low in the first cycle out of reset, so the
  // first request rises on the first posedge after reset deasserts.
  assign fetch_done = (state_q == S_FETCH) && started_q && im_ready;
  assign retire     = (state_q == S_EXEC) && pc_write;

`ifdef PC_MISALIGN_TRAP_EN
  assign bad_target = !is_aligned(next_pc[1:0]);
  assign load_value = next_pc;
`else
  assign bad_target = 1'b0;
  assign load_value = {next_pc[PcSize-1:2], 2'b00};
`endif

  assign pc_load = retire && !bad_target;

  // Next-state logic: fetch until accepted, execute until retired, then
  // either fetch again or park in S_HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (fetch_done) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (retire) state_d = (bad_target || halt) ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (!halt && !fault_q) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // FSM state register plus the one-shot "out of reset" flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
    end
  end

  // PC register: loads only when an instruction retires with a usable target.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= ResetPc;
    end else if (pc_load) begin
      pc_q <= load_value;
    end
  end

  // Instruction register: captures the memory word on the accepting cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_q <= '0;
    end else if (fetch_done) begin
      instr_q <= im_rdata;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Sticky alignment fault, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else if (retire && bad_target) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign fault_q = 1'b0;
`endif

  assign im_req         = (state_q == S_FETCH) && started_q;
  assign im_addr        = pc_q;
  assign current_pc     = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = (state_q == S_EXEC);
  assign halted         = (state_q == S_HALT);
  assign misalign_fault = fault_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: a random-ready instruction memory, a retire driver
// that feeds next_pc/halt, a reference model of the PC sequence and a
// scoreboard checking every fetched (pc, word) pair as it reaches decode.
module tb_pc_fetch;

  localparam int              PW       = 10;
  localparam int              DW       = 32;
  localparam logic [PW-1:0]   RESET_PC = 10'd0;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  initial forever #5 clock = ~clock;

  logic          halt     = 1'b0;
  logic          pc_write = 1'b0;
  logic [PW-1:0] next_pc  = '0;
  logic          im_req;
  logic [PW-1:0] im_addr;
  logic          im_ready = 1'b0;
  logic [DW-1:0] im_rdata;
  logic [PW-1:0] current_pc;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          halted;
  logic          misalign_fault;
  logic [1:0]    fsm_state;

  pc_fetch #(
    .PcSize  (PW),
    .DataSize(DW),
    .ResetPc (RESET_PC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .halt          (halt),
    .pc_write      (pc_write),
    .next_pc       (next_pc),
    .im_req        (im_req),
    .im_addr       (im_addr),
    .im_ready      (im_ready),
    .im_rdata      (im_rdata),
    .current_pc    (current_pc),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .misalign_fault(misalign_fault),
    .fsm_state     (fsm_state)
  );

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [256];
  int            rdy_mode = 0; // 0 random, 1 always ready, 2 never ready

  assign im_rdata = mem[im_addr[9:2]];

  always @(negedge clock) begin
    #2;
    case (rdy_mode)
      1:       im_ready = 1'b1;
      2:       im_ready = 1'b0;
      default: im_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [PW+DW-1:0] exp_q[$];
  int               vectors     = 0;
  int               miscompares = 0;
  logic [PW-1:0]    model_pc;
  logic             model_fault;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_expected();
    exp_q.push_back({model_pc, mem[model_pc[9:2]]});
  endtask

  // ---------------- monitor ----------------
  logic             prev_req   = 1'b0;
  logic             prev_valid = 1'b0;
  logic [PW-1:0]    prev_addr  = '0;
  logic [PW+DW-1:0] exp_e;

  // Checks the memory handshake rules and scores each newly presented instruction.
  always @(negedge clock) begin
    if (!reset) begin
      prev_req   = 1'b0;
      prev_valid = 1'b0;
      prev_addr  = '0;
    end else begin
      if (prev_req) begin
        if (im_ready) begin
          chk("accept_to_valid", instr_valid, 1'b1);
        end else begin
          chk("req_held", im_req, 1'b1);
          chk("addr_stable", im_addr, prev_addr);
        end
      end
      if (instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_fetch: pc 0x%0h presented with no expected entry", current_pc);
        end else begin
          exp_e = exp_q.pop_front();
          chk("fetch_pc", current_pc, exp_e[PW+DW-1:DW]);
          chk("fetch_word", instr, exp_e[DW-1:0]);
        end
      end
      prev_req   = im_req;
      prev_valid = instr_valid;
      prev_addr  = im_addr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_valid(output logic got);
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (instr_valid) begin
        got = 1'b1;
        break;
      end
      // pc_write outside S_EXEC must be ignored
      pc_write = ($urandom_range(0, 3) == 0);
      next_pc  = 10'($urandom);
      step();
    end
    pc_write = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL valid_timeout: instr_valid still 0 after 64 cycles");
    end
  endtask

  task automatic retire(input logic [PW-1:0] nxt, input logic h);
    logic got;
    logic exp_halt;
    int   n;
    halt = h;
    wait_valid(got);
    if (got) begin
      n = $urandom_range(0, 2);
      repeat (n) step();
      chk("exec_hold", instr_valid, 1'b1);
      pc_write = 1'b1;
      next_pc  = nxt;
`ifdef PC_MISALIGN_TRAP_EN
      if ((nxt % 4) != 0) begin
        model_fault = 1'b1;
        exp_halt    = 1'b1;
      end else begin
        model_pc = nxt;
        exp_halt = h;
        push_expected();
      end
`else
      model_pc = 10'((nxt / 4) * 4);
      exp_halt = h;
      push_expected();
`endif
      step();
      pc_write = 1'b0;
      next_pc  = 10'($urandom);
      chk("pc_load", current_pc, model_pc);
      chk("halted", halted, exp_halt);
      chk("fault", misalign_fault, model_fault);
      chk("retire_valid_off", instr_valid, 1'b0);
      if (exp_halt) begin
        chk("halt_req_off", im_req, 1'b0);
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
          pc_write = $urandom_range(0, 1);
          next_pc  = 10'($urandom);
          step();
          chk("halt_hold", halted, 1'b1);
        end
        pc_write = 1'b0;
        chk("halt_pc_hold", current_pc, model_pc);
        halt = 1'b0;
        step();
        chk("halt_release", halted, model_fault);
        if (model_fault) begin
          repeat (3) begin
            step();
            chk("fault_stuck", halted, 1'b1);
          end
        end
      end else begin
        chk("refetch_req", im_req, 1'b1);
        chk("refetch_addr", im_addr, model_pc);
      end
    end
    halt = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, "_req"}, im_req, 1'b0);
    chk({tag, "_valid"}, instr_valid, 1'b0);
    chk({tag, "_pc"}, current_pc, RESET_PC);
    chk({tag, "_halted"}, halted, 1'b0);
    chk({tag, "_fault"}, misalign_fault, 1'b0);
    chk({tag, "_instr"}, instr, '0);
    halt     = 1'b0;
    pc_write = 1'b0;
    repeat (2) step();
    exp_q.delete();
    model_pc    = RESET_PC;
    model_fault = 1'b0;
    push_expected();
    reset = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic          got;
    logic [PW-1:0] nxt;
    logic          h;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h1234_5678;
    model_pc    = RESET_PC;
    model_fault = 1'b0;
    push_expected();
    rdy_mode = 1;

    // reset state and first fetch with memory always ready
    repeat (3) step();
    chk("rst_req", im_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_pc", current_pc, RESET_PC);
    chk("rst_instr", instr, '0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_fault", misalign_fault, 1'b0);
    reset = 1'b1;
    step();
    chk("first_req", im_req, 1'b1);
    chk("first_addr", im_addr, 10'h000);
    chk("first_valid_low", instr_valid, 1'b0);
    step();
    chk("first_instr", instr, 32'h1234_5678);
    chk("first_valid", instr_valid, 1'b1);
    chk("first_pc", current_pc, 10'h000);

    // sequential load, top of address space, wrap to zero
    retire(10'h004, 1'b0);
    retire(10'h3FC, 1'b0);
    retire(10'h000, 1'b0);

    // memory stalls three cycles
    retire(10'h008, 1'b0);
    rdy_mode = 2;
    repeat (3) begin
      step();
      chk("stall_req", im_req, 1'b1);
      chk("stall_addr", im_addr, 10'h008);
      chk("stall_valid", instr_valid, 1'b0);
    end
    rdy_mode = 1;
    step();
    chk("stall_done", instr_valid, 1'b1);

    // halt raised while fetching, plus halt together with the retiring pc_write
    rdy_mode = 0;
    retire(10'h00C, 1'b0);
    retire(10'h010, 1'b1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
`ifdef PC_MISALIGN_TRAP_EN
      nxt = 10'($urandom_range(0, 255) * 4);
`else
      nxt = 10'($urandom);
`endif
      h = ($urandom_range(0, 4) == 0);
      retire(nxt, h);
    end

    // reset while a request is outstanding, then while executing
    retire(10'h020, 1'b0);
    rdy_mode = 2;
    step();
    chk("pre_rst_req", im_req, 1'b1);
    do_reset("rst_fetch");
    rdy_mode = 0;
    wait_valid(got);
    do_reset("rst_exec");

    // misaligned target
    retire(10'h004, 1'b0);
    retire(10'h006, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("trap_pc", current_pc, 10'h004);
    do_reset("post_fault");
`else
    chk("force_align_pc", current_pc, 10'h004);
`endif

    // last outstanding fetch must arrive and leave nothing behind
    wait_valid(got);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
